// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
package mc_pkg;

   typedef enum logic [3:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_REXE,
      S_RWB,
      S_IEXE,
      S_IWB,
      S_BRANCH,
      S_JUMP
   } state_t;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [2:0] OP_IALU_PFX = 3'b001;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_IOP   = 2'b11;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Dispatch target out of DECODE; S_FETCH means the opcode is not decodable.
   function automatic state_t decode_next(input logic [5:0] op);
      if (op == OP_R)
         return S_REXE;
      else if (op == OP_LW || op == OP_SW)
         return S_MEMADR;
      else if (op == OP_BEQ || op == OP_BNE)
         return S_BRANCH;
      else if (op == OP_J)
         return S_JUMP;
      else if (op[5:3] == OP_IALU_PFX)
         return S_IEXE;
      else
         return S_FETCH;
   endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
//
// state    | meaning
// RESET    | idle after reset, all controls low
// FETCH    | read instruction at PC, PC += 4 on grant
// DECODE   | latch opcode, precompute branch target
// MEMADR   | compute load/store address
// MEMRD    | load data read
// MEMWB    | load data write-back (retire)
// MEMWR    | store data write (retire on grant)
// REXE     | R-type ALU operation
// RWB      | R-type write-back (retire)
// IEXE     | I-type ALU operation
// IWB      | I-type write-back (retire)
// BRANCH   | beq/bne compare and conditional PC load (retire)
// JUMP     | unconditional PC load (retire)
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             MemWrite,
   output logic             IorD,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             branch_ne,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [2:0]       i_op,
   output logic             zero_ext,
   output logic [1:0]       PCSrc,
   output logic             instr_done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   state_t     state_q;
   state_t     state_d;
   logic [5:0] op_q;

   // i_op and branch_ne follow op_q so they hold from DECODE to the next DECODE.
   assign i_op      = op_q[2:0];
   assign branch_ne = op_q[0];
   assign zero_ext  = (op_q[2:0] == 3'b100) || (op_q[2:0] == 3'b101) ||
                      (op_q[2:0] == 3'b110);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_RESET;
         op_q        <= '0;
         instr_count <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE)
            op_q <= opcode;
         if (instr_done)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      MemWrite    = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALUOP_ADD;
      PCSrc       = PCSRC_ALU;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready)
               state_d = S_DECODE;
         end
         // Dispatch from the live opcode: it is the value being latched into op_q.
         S_DECODE: begin
            ALUSrcB = SRCB_IMM_SH;
            state_d = decode_next(opcode);
            if (state_d == S_FETCH)
               illegal_op = 1'b1;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
            if (mem_ready)
               state_d = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = mem_ready;
            if (mem_ready)
               state_d = S_FETCH;
         end
         S_REXE: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
            state_d = S_RWB;
         end
         S_RWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_IEXE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_IOP;
            state_d = S_IWB;
         end
         S_IWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCSrc       = PCSRC_ALUOUT;
            PCWriteCond = 1'b1;
            instr_done  = 1'b1;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSrc      = PCSRC_JUMP;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle control vectors plus reset
// and counter-wrap sequences.
module tb_mc_control_fsm;

   localparam int CW = 4;

   // {mem_req,MemWrite,IorD,IRWrite,PCWrite,PCWriteCond,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,instr_done,illegal_op}
   localparam logic [17:0] C_RST  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] C_F1   = 18'b1_0_0_1_1_0_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] C_F0   = 18'b1_0_0_0_0_0_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] C_DEC  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
   localparam logic [17:0] C_DILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
   localparam logic [17:0] C_MADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [17:0] C_MRD  = 18'b1_0_1_0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] C_MWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
   localparam logic [17:0] C_MWR1 = 18'b1_1_1_0_0_0_0_0_0_0_00_00_00_1_0;
   localparam logic [17:0] C_MWR0 = 18'b1_1_1_0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] C_REXE = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
   localparam logic [17:0] C_RWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
   localparam logic [17:0] C_IEXE = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_0_0;
   localparam logic [17:0] C_IWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
   localparam logic [17:0] C_BR   = 18'b0_0_0_0_0_1_0_0_0_1_00_01_01_1_0;
   localparam logic [17:0] C_JMP  = 18'b0_0_0_0_1_0_0_0_0_0_00_00_10_1_0;

   localparam logic [5:0] R   = 6'b000000;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] BNE = 6'b000101;
   localparam logic [5:0] J   = 6'b000010;
   localparam logic [5:0] ORI = 6'b001101;
   localparam logic [5:0] ADI = 6'b001000;
   localparam logic [5:0] ILL = 6'b111111;

   typedef struct {
      logic [5:0]    op;
      logic          rdy;
      logic [17:0]   ctl;
      logic [CW-1:0] cnt;
      logic          chk_ext;
      logic [2:0]    iop;
      logic          zx;
      logic          bne;
   } vec_t;

   logic          clk;
   logic          rst;
   logic [5:0]    opcode;
   logic          mem_ready;
   logic          mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
   logic          branch_ne, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0]    ALUSrcB, ALUOp, PCSrc;
   logic [2:0]    i_op;
   logic          zero_ext, instr_done, illegal_op;
   logic [CW-1:0] instr_count;
   logic [17:0]   act_ctl;

   int checks   = 0;
   int failures = 0;
   vec_t vecs[$];

   mc_control_fsm #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .branch_ne(branch_ne),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .i_op(i_op),
      .zero_ext(zero_ext), .PCSrc(PCSrc), .instr_done(instr_done),
      .illegal_op(illegal_op), .instr_count(instr_count)
   );

   assign act_ctl = {mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, RegDst,
                     MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
                     instr_done, illegal_op};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t v(input logic [5:0] op, input logic rdy, input logic [17:0] ctl,
                              input logic [CW-1:0] cnt);
      vec_t r;
      r.op = op; r.rdy = rdy; r.ctl = ctl; r.cnt = cnt;
      r.chk_ext = 1'b0; r.iop = 3'b000; r.zx = 1'b0; r.bne = 1'b0;
      return r;
   endfunction

   function automatic vec_t vx(input logic [5:0] op, input logic [17:0] ctl,
                               input logic [CW-1:0] cnt, input logic [2:0] iop,
                               input logic zx, input logic bne);
      vec_t r;
      r = v(op, 1'b1, ctl, cnt);
      r.chk_ext = 1'b1; r.iop = iop; r.zx = zx; r.bne = bne;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      opcode = R;
      mem_ready = 1'b1;
      #1;
      chk("reset_ctl", -1, 32'(act_ctl), 32'(C_RST));
      chk("reset_cnt", -1, 32'(instr_count), 32'd0);

      // Each row is one clock cycle after reset release.
      vecs.push_back(v(R,   1'b1, C_RST,  4'd0));
      vecs.push_back(v(R,   1'b1, C_F1,   4'd0));
      vecs.push_back(v(R,   1'b1, C_DEC,  4'd0));
      vecs.push_back(v(R,   1'b1, C_REXE, 4'd0));
      vecs.push_back(v(R,   1'b1, C_RWB,  4'd0));
      vecs.push_back(v(ORI, 1'b1, C_F1,   4'd1));
      vecs.push_back(v(ORI, 1'b1, C_DEC,  4'd1));
      vecs.push_back(vx(ORI, C_IEXE, 4'd1, 3'b101, 1'b1, 1'b1));
      vecs.push_back(v(ORI, 1'b1, C_IWB,  4'd1));
      vecs.push_back(v(ADI, 1'b1, C_F1,   4'd2));
      vecs.push_back(v(ADI, 1'b1, C_DEC,  4'd2));
      vecs.push_back(vx(ADI, C_IEXE, 4'd2, 3'b000, 1'b0, 1'b0));
      vecs.push_back(v(ADI, 1'b1, C_IWB,  4'd2));
      vecs.push_back(v(LW,  1'b1, C_F1,   4'd3));
      vecs.push_back(v(LW,  1'b1, C_DEC,  4'd3));
      vecs.push_back(v(LW,  1'b1, C_MADR, 4'd3));
      vecs.push_back(v(LW,  1'b0, C_MRD,  4'd3));
      vecs.push_back(v(LW,  1'b0, C_MRD,  4'd3));
      vecs.push_back(v(LW,  1'b1, C_MRD,  4'd3));
      vecs.push_back(v(LW,  1'b1, C_MWB,  4'd3));
      vecs.push_back(v(SW,  1'b0, C_F0,   4'd4));
      vecs.push_back(v(SW,  1'b1, C_F1,   4'd4));
      vecs.push_back(v(SW,  1'b1, C_DEC,  4'd4));
      vecs.push_back(v(SW,  1'b1, C_MADR, 4'd4));
      vecs.push_back(v(SW,  1'b0, C_MWR0, 4'd4));
      vecs.push_back(v(SW,  1'b1, C_MWR1, 4'd4));
      vecs.push_back(v(BNE, 1'b1, C_F1,   4'd5));
      vecs.push_back(v(BNE, 1'b1, C_DEC,  4'd5));
      vecs.push_back(vx(BNE, C_BR, 4'd5, 3'b101, 1'b1, 1'b1));
      vecs.push_back(v(BEQ, 1'b1, C_F1,   4'd6));
      vecs.push_back(v(BEQ, 1'b1, C_DEC,  4'd6));
      vecs.push_back(vx(BEQ, C_BR, 4'd6, 3'b100, 1'b1, 1'b0));
      vecs.push_back(v(J,   1'b1, C_F1,   4'd7));
      vecs.push_back(v(J,   1'b1, C_DEC,  4'd7));
      vecs.push_back(vx(J, C_JMP, 4'd7, 3'b010, 1'b0, 1'b0));
      vecs.push_back(v(ILL, 1'b1, C_F1,   4'd8));
      vecs.push_back(v(ILL, 1'b1, C_DILL, 4'd8));
      vecs.push_back(v(J,   1'b1, C_F1,   4'd8));
      vecs.push_back(v(J,   1'b1, C_DEC,  4'd8));
      vecs.push_back(v(J,   1'b1, C_JMP,  4'd8));
      vecs.push_back(v(LW,  1'b1, C_F1,   4'd9));

      tick();
      tick();
      rst = 1'b0;
      foreach (vecs[i]) begin
         opcode    = vecs[i].op;
         mem_ready = vecs[i].rdy;
         #1;
         chk("ctl", i, 32'(act_ctl), 32'(vecs[i].ctl));
         chk("count", i, 32'(instr_count), 32'(vecs[i].cnt));
         if (vecs[i].chk_ext) begin
            chk("i_op", i, 32'(i_op), 32'(vecs[i].iop));
            chk("zero_ext", i, 32'(zero_ext), 32'(vecs[i].zx));
            chk("branch_ne", i, 32'(branch_ne), 32'(vecs[i].bne));
         end
         tick();
      end

      // Now in DECODE of a lw; stall in MEMRD, then reset mid-access.
      mem_ready = 1'b0;
      tick();
      tick();
      chk("memrd_req", 0, 32'(act_ctl), 32'(C_MRD));
      rst = 1'b1;
      #1;
      chk("rst_mid_ctl", 0, 32'(act_ctl), 32'(C_RST));
      chk("rst_mid_cnt", 0, 32'(instr_count), 32'd0);
      chk("rst_mid_iop", 0, 32'(i_op), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst_release_ctl", 0, 32'(act_ctl), 32'(C_RST));
      tick();
      chk("first_fetch", 0, 32'(act_ctl), 32'(C_F0));

      // Sixteen jumps wrap the 4-bit counter back to zero.
      opcode    = J;
      mem_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         tick();
         tick();
         if (k == 15 || k == 16)
            chk("wrap_cnt", k, 32'(instr_count), 32'(k % 16));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
